// File: rtl/serial_tx_pkg.sv
// Shared types for the serial transmit controller.
// Holds the controller state encoding and its width.
package serial_tx_pkg;

    localparam int STATE_W = 2;

    typedef enum logic [STATE_W-1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        LATCH = 2'd2
    } state_e;

endpackage

// File: rtl/serial_tx_ctrl_piso_reg.sv
// piso_reg: WIDTH-bit parallel-load, right-shift register (MSB fills 0).
// Ports: clk, rst (sync, active-high), load (priority), shift, d, q.
module piso_reg #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             shift,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] sr_q;
    logic [WIDTH-1:0] sr_d;

    always_comb begin
        sr_d = sr_q;
        if (load) begin
            sr_d = d;
        end else if (shift) begin
            sr_d = {1'b0, sr_q[WIDTH-1:1]};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sr_q <= '0;
        end else begin
            sr_q <= sr_d;
        end
    end

    assign q = sr_q;

endmodule

// File: rtl/serial_tx_ctrl.sv
// serial_tx_ctrl: accepts a WIDTH-bit word on valid/ready, shifts it out
// LSB-first on sdata with divided sclk, then pulses sload for one bit time.
// Ports: clk, rst (sync, active-high), din/din_valid/din_ready handshake,
// sclk/sdata/sload serial outputs, busy (= !din_ready).
module serial_tx_ctrl #(
    parameter int WIDTH = 8,
    parameter int DIV   = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    output logic             din_ready,
    output logic             sclk,
    output logic             sdata,
    output logic             sload,
    output logic             busy
);

    import serial_tx_pkg::*;

    localparam int BW = $clog2(WIDTH);
    localparam int DW = $clog2(DIV);
    localparam logic [BW-1:0] BIT_LAST = BW'(WIDTH - 1);
    localparam logic [BW-1:0] BIT_ONE  = BW'(1);
    localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);
    localparam logic [DW-1:0] DIV_HALF = DW'(DIV / 2);
    localparam logic [DW-1:0] DIV_ONE  = DW'(1);

    state_e        state_q, state_d;
    logic [BW-1:0] bit_q, bit_d;
    logic [DW-1:0] div_q, div_d;
    logic          ready_q, ready_d;
    logic          sclk_q, sclk_d;
    logic          sload_q, sload_d;
    logic          load, shift, div_end;
    logic [WIDTH-1:0] sr_q;
    logic          unused_sr;

    piso_reg #(.WIDTH(WIDTH)) u_piso (
        .clk   (clk),
        .rst   (rst),
        .load  (load),
        .shift (shift),
        .d     (din),
        .q     (sr_q)
    );

    // The register drains to zero after WIDTH shifts, so bit 0 is
    // already 0 in LATCH and IDLE and can drive sdata directly.
    assign unused_sr = ^sr_q[WIDTH-1:1];

    always_comb begin
        state_d = state_q;
        bit_d   = bit_q;
        div_d   = div_q;
        load    = 1'b0;
        shift   = 1'b0;
        div_end = (div_q == DIV_LAST);
        unique case (state_q)
            IDLE: begin
                if (din_valid && ready_q) begin
                    load    = 1'b1;
                    bit_d   = '0;
                    div_d   = '0;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                if (div_end) begin
                    div_d = '0;
                    shift = 1'b1;
                    if (bit_q == BIT_LAST) begin
                        bit_d   = '0;
                        state_d = LATCH;
                    end else begin
                        bit_d = bit_q + BIT_ONE;
                    end
                end else begin
                    div_d = div_q + DIV_ONE;
                end
            end
            LATCH: begin
                if (div_end) begin
                    div_d   = '0;
                    state_d = IDLE;
                end else begin
                    div_d = div_q + DIV_ONE;
                end
            end
            default: state_d = IDLE;
        endcase
        // Outputs are decoded from next state so they come straight off flops.
        ready_d = (state_d == IDLE);
        sload_d = (state_d == LATCH);
        sclk_d  = (state_d == SHIFT) && (div_d >= DIV_HALF);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            bit_q   <= '0;
            div_q   <= '0;
            ready_q <= 1'b1;
            sclk_q  <= 1'b0;
            sload_q <= 1'b0;
        end else begin
            state_q <= state_d;
            bit_q   <= bit_d;
            div_q   <= div_d;
            ready_q <= ready_d;
            sclk_q  <= sclk_d;
            sload_q <= sload_d;
        end
    end

    assign din_ready = ready_q;
    assign busy      = ~ready_q;
    assign sclk      = sclk_q;
    assign sload     = sload_q;
    assign sdata     = sr_q[0];

endmodule

// File: tb/tb_serial_tx_ctrl.sv
// Self-checking bench for serial_tx_ctrl: directed vectors, multi-cycle
// corner cases and a randomized run against a frame-timeline model.
module tb_serial_tx_ctrl;

    localparam int W  = 8;
    localparam int D  = 4;
    localparam int W2 = 4;
    localparam int D2 = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic [7:0] din;
    logic       din_valid;
    logic       din_ready, sclk, sdata, sload, busy;
    logic [3:0] din2;
    logic       din_valid2;
    logic       din_ready2, sclk2, sdata2, sload2, busy2;

    int checks = 0;
    int errors = 0;
    logic inv_en = 1'b0;

    serial_tx_ctrl #(.WIDTH(W), .DIV(D)) u_dut (
        .clk(clk), .rst(rst), .din(din), .din_valid(din_valid),
        .din_ready(din_ready), .sclk(sclk), .sdata(sdata),
        .sload(sload), .busy(busy)
    );

    serial_tx_ctrl #(.WIDTH(W2), .DIV(D2)) u_small (
        .clk(clk), .rst(rst), .din(din2), .din_valid(din_valid2),
        .din_ready(din_ready2), .sclk(sclk2), .sdata(sdata2),
        .sload(sload2), .busy(busy2)
    );

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Invariants on both instances, sampled on the falling edge.
    logic p_sdata = 1'b0;
    logic p_sdata2 = 1'b0;
    always @(negedge clk) begin
        if (inv_en) begin
            chk("inv_sdata_hold", 32'(sclk && (sdata !== p_sdata)), 32'd0);
            chk("inv_sload_sclk", 32'(sload && sclk), 32'd0);
            chk("inv_busy", 32'(busy), 32'(!din_ready));
            chk("inv_sdata_hold2", 32'(sclk2 && (sdata2 !== p_sdata2)), 32'd0);
            chk("inv_sload_sclk2", 32'(sload2 && sclk2), 32'd0);
            chk("inv_busy2", 32'(busy2), 32'(!din_ready2));
        end
        p_sdata  = sdata;
        p_sdata2 = sdata2;
    end

    // Starts on cycle 1 of a frame; walks until din_ready or the bound.
    task automatic capture(output logic [0:7] bits, output int nbits,
                           output int first_rise, output int sl_first,
                           output int sl_cnt, output int rdy_at);
        logic prev;
        int c;
        bits = '0; nbits = 0; first_rise = -1;
        sl_first = -1; sl_cnt = 0; rdy_at = -1;
        prev = 1'b0; c = 1;
        while (c <= 60 && rdy_at < 0) begin
            if (sclk && !prev) begin
                if (nbits < 8) bits[nbits] = sdata;
                if (first_rise < 0) first_rise = c;
                nbits++;
            end
            prev = sclk;
            if (sload) begin
                if (sl_first < 0) sl_first = c;
                sl_cnt++;
            end
            if (din_ready) rdy_at = c;
            else begin
                tick();
                c++;
            end
        end
    endtask

    task automatic check_frame(input string tag, input logic [0:7] seq);
        logic [0:7] b;
        int nb, fr, sf, sc, ra;
        capture(b, nb, fr, sf, sc, ra);
        chk({tag, "_bits"}, 32'(b), 32'(seq));
        chk({tag, "_nbits"}, nb, W);
        chk({tag, "_rise0"}, fr, 1 + D / 2);
        chk({tag, "_sload_start"}, sf, W * D + 1);
        chk({tag, "_sload_len"}, sc, D);
        chk({tag, "_ready_at"}, ra, (W + 1) * D + 1);
    endtask

    // Model: n = cycles since handshake (1 = first SHIFT cycle), -1 idle.
    // Returns {din_ready, sclk, sdata, sload}.
    function automatic logic [3:0] exp_out(int n, logic [7:0] w);
        int k, ph;
        if (n < 1) return 4'b1000;
        if (n <= W * D) begin
            k  = (n - 1) / D;
            ph = (n - 1) % D;
            return {1'b0, (ph >= D / 2), w[k], 1'b0};
        end
        return 4'b0001;
    endfunction

    typedef struct packed {
        logic [7:0] din;
        logic [0:7] seq;
        logic       tog;
    } vec_t;

    vec_t vecs[3];

    initial begin
        logic [0:3] b2;
        int nb2, r_first, r_prev, r_bad, sl2, rdy2, sl, n;
        logic [7:0] mw;
        logic [3:0] e;

        vecs[0] = '{din: 8'hA5, seq: 8'b10100101, tog: 1'b0};
        vecs[1] = '{din: 8'h3C, seq: 8'b00111100, tog: 1'b0};
        vecs[2] = '{din: 8'h0F, seq: 8'b11110000, tog: 1'b1};

        rst = 1'b1; din = '0; din_valid = 1'b0;
        din2 = '0; din_valid2 = 1'b0;
        tick();
        tick();
        chk("rst_ready", 32'(din_ready), 32'd1);
        chk("rst_sclk", 32'(sclk), 32'd0);
        chk("rst_sdata", 32'(sdata), 32'd0);
        chk("rst_sload", 32'(sload), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_ready2", 32'(din_ready2), 32'd1);
        rst = 1'b0;
        inv_en = 1'b1;
        tick();

        for (int i = 0; i < 3; i++) begin
            din = vecs[i].din;
            din_valid = 1'b1;
            chk("vec_ready", 32'(din_ready), 32'd1);
            tick();
            din_valid = vecs[i].tog;
            if (vecs[i].tog) din = 8'hFF;
            check_frame($sformatf("vec%0d", i), vecs[i].seq);
            din_valid = 1'b0;
            tick();
        end

        // Back-to-back: valid held, second word taken on the ready cycle.
        din = 8'hA5; din_valid = 1'b1;
        tick();
        din = 8'h3C;
        check_frame("b2b_first", 8'b10100101);
        tick();
        chk("b2b_no_gap", 32'(busy), 32'd1);
        din_valid = 1'b0;
        check_frame("b2b_second", 8'b00111100);
        tick();

        // Abort at cycle 10, then reset dominating a handshake in IDLE.
        din = 8'hA5; din_valid = 1'b1;
        tick();
        din_valid = 1'b0;
        repeat (9) tick();
        rst = 1'b1; din_valid = 1'b1;
        tick();
        chk("abort_sclk", 32'(sclk), 32'd0);
        chk("abort_sdata", 32'(sdata), 32'd0);
        chk("abort_sload", 32'(sload), 32'd0);
        chk("abort_ready", 32'(din_ready), 32'd1);
        tick();
        chk("rst_dominates", 32'(din_ready), 32'd1);
        rst = 1'b0; din_valid = 1'b0;
        sl = 0;
        repeat (45) begin
            tick();
            if (sload) sl++;
        end
        chk("abort_no_sload", sl, 0);

        // Small instance: WIDTH=4, DIV=2.
        din2 = 4'b1001; din_valid2 = 1'b1;
        tick();
        din_valid2 = 1'b0;
        b2 = '0; nb2 = 0; r_first = -1; r_prev = -1; r_bad = 0;
        sl2 = 0; rdy2 = -1;
        begin
            logic prev2;
            int c;
            prev2 = 1'b0; c = 1;
            while (c <= 30 && rdy2 < 0) begin
                if (sclk2 && !prev2) begin
                    if (nb2 < 4) b2[nb2] = sdata2;
                    nb2++;
                    if (r_first < 0) r_first = c;
                    else if (c - r_prev != D2) r_bad++;
                    r_prev = c;
                end
                prev2 = sclk2;
                if (sload2) sl2++;
                if (din_ready2) rdy2 = c;
                else begin
                    tick();
                    c++;
                end
            end
        end
        chk("small_bits", 32'(b2), 32'(4'b1001));
        chk("small_nbits", nb2, W2);
        chk("small_rise0", r_first, 1 + D2 / 2);
        chk("small_sclk_period", r_bad, 0);
        chk("small_sload_len", sl2, D2);
        chk("small_ready_at", rdy2, (W2 + 1) * D2 + 1);
        tick();

        // Randomized run against the timeline model.
        n = -1; mw = '0;
        for (int i = 0; i < 3000; i++) begin
            e = exp_out(n, mw);
            chk("rand_out", 32'({din_ready, sclk, sdata, sload}), 32'(e));
            rst = ($urandom_range(0, 149) == 0);
            din_valid = ($urandom_range(0, 2) == 0);
            din = 8'($urandom);
            if (rst) n = -1;
            else if (n < 1 && din_valid) begin
                n = 1;
                mw = din;
            end else if (n >= 1) begin
                n++;
                if (n > (W + 1) * D) n = -1;
            end
            tick();
        end
        rst = 1'b0; din_valid = 1'b0;
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
